// File: rtl/iwt_unsquash.sv
// -----------------------------------------------------------------------------
// iwt_unsquash
//   Inverse of a one-level integer (lifting) Haar transform. Each accepted
//   coefficient pair (L, H) is turned back into two samples, emitted as the
//   even sample first and then the odd sample, one per cycle:
//       even = L - (H >> 1)      odd = H + even      (all modulo 2^W)
//   A frame is PAIRS pairs; out_last marks its final (odd) sample.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_L/in_H hold a coefficient pair
//   in_ready   a pair is accepted this cycle when in_valid is also high
//   in_L       low-band coefficient  (W bits)
//   in_H       high-band coefficient (W bits)
//   out_valid  out_data holds a reconstructed sample
//   out_ready  downstream takes out_data this cycle
//   out_data   reconstructed sample (W bits), even first then odd
//   out_last   high on the last sample of a frame
// -----------------------------------------------------------------------------
module iwt_unsquash #(
    parameter int PAIRS = 32,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_L,
    input  logic [W-1:0] in_H,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    // A one-pair frame still needs a 1-bit counter to keep the logic legal.
    localparam int CW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] LAST_PAIR = CW'(PAIRS - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        EVEN  = 2'd1,
        ODD   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  even_q, even_d;
    logic [W-1:0]  odd_q, odd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;

    logic [W-1:0]  rec_even;
    logic [W-1:0]  rec_odd;
    logic          pair_xfer;
    logic          samp_xfer;

    // Reconstruction of the incoming pair; only used when a pair transfers.
    assign rec_even = in_L - (in_H >> 1);
    assign rec_odd  = in_H + rec_even;

    // ODD can take the next pair in the same cycle its odd sample leaves,
    // which is what keeps the output stream gap-free.
    assign in_ready  = (state_q == EMPTY) || ((state_q == ODD) && out_ready);
    assign pair_xfer = in_valid && in_ready;
    assign samp_xfer = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        even_d  = even_q;
        odd_d   = odd_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (pair_xfer) begin
                    even_d  = rec_even;
                    odd_d   = rec_odd;
                    state_d = EVEN;
                end
            end
            EVEN: begin
                if (samp_xfer) begin
                    state_d = ODD;
                end
            end
            ODD: begin
                if (samp_xfer) begin
                    // Counter tracks completed pairs within the frame.
                    cnt_d = (cnt_q == LAST_PAIR) ? '0 : cnt_q + CW'(1);
                    if (pair_xfer) begin
                        even_d  = rec_even;
                        odd_d   = rec_odd;
                        state_d = EVEN;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Outputs are registered from the next-state view so they change
        // only on a clock edge and never see in_* combinationally.
        out_valid_d = (state_d != EMPTY);
        out_last_d  = (state_d == ODD) && (cnt_d == LAST_PAIR);
        out_data_d  = (state_d == ODD) ? odd_d : even_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            even_q      <= '0;
            odd_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            even_q      <= even_d;
            odd_q       <= odd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_iwt_unsquash.sv
// -----------------------------------------------------------------------------
// tb_iwt_unsquash
//   Self-checking bench for iwt_unsquash (PAIRS=32, W=8). Original sample
//   pairs are pushed through a forward-transform model to make (L, H); every
//   accepted pair queues its original samples, and a monitor compares each
//   delivered sample (data and frame-last flag) against that queue.
// -----------------------------------------------------------------------------
module tb_iwt_unsquash;

    localparam int PAIRS = 32;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_L;
    logic [W-1:0] in_H;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    // Original samples belonging to the pair currently on in_L/in_H.
    logic [W-1:0] drv_e;
    logic [W-1:0] drv_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    int           frame_idx = 0;
    int           log_data[$];
    int           log_last[$];
    int           log_cyc[$];
    logic         toggle_en = 1'b0;

    iwt_unsquash #(.PAIRS(PAIRS), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_L      (in_L),
        .in_H      (in_H),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Forward lifting transform: H = odd - even, L = even + (H >> 1).
    function automatic void fwd(input logic [W-1:0] e, input logic [W-1:0] o,
                                output logic [W-1:0] l, output logic [W-1:0] h);
        h = o - e;
        l = e + (h >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        logic         have_prev;
        logic         prev_valid, prev_ready, prev_last;
        logic [W-1:0] prev_data;
        logic [W-1:0] exp_d;
        int           exp_l;
        have_prev = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                frame_idx = 0;
                have_prev = 1'b0;
            end else begin
                if (have_prev && prev_valid && !prev_ready) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(out_data), int'(prev_data));
                    chk("hold_last", int'(out_last), int'(prev_last));
                end
                if (!out_valid) begin
                    chk("idle_last", int'(out_last), 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_sample: got %0d, expected no sample", out_data);
                    end else begin
                        exp_d = exp_q.pop_front();
                        exp_l = (frame_idx == 2 * PAIRS - 1) ? 1 : 0;
                        chk("sample_data", int'(out_data), int'(exp_d));
                        chk("sample_last", int'(out_last), exp_l);
                        frame_idx = (frame_idx + 1) % (2 * PAIRS);
                    end
                    log_data.push_back(int'(out_data));
                    log_last.push_back(int'(out_last));
                    log_cyc.push_back(cyc);
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(drv_e);
                    exp_q.push_back(drv_o);
                end
                have_prev  = 1'b1;
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    // Random downstream backpressure, enabled only during the frame test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one pair (from original samples) and hold it until accepted.
    // Returns just after the accepting edge; acc_cyc is that edge's count.
    task automatic send(input logic [W-1:0] e, input logic [W-1:0] o, output int acc_cyc);
        logic [W-1:0] l, h;
        int n;
        fwd(e, o, l, h);
        in_L = l; in_H = h; drv_e = e; drv_o = o;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        in_L = W'($urandom);
        in_H = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, acc, lasts;
        logic [W-1:0] l, h, e, o;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_L = '0; in_H = '0; drv_e = '0; drv_o = '0;

        // Pin the forward model against hand-computed pairs.
        fwd(8'd145, 8'd56, l, h);
        chk("model_L_a", int'(l), 228); chk("model_H_a", int'(h), 167);
        fwd(8'd49, 8'd89, l, h);
        chk("model_L_b", int'(l), 69);  chk("model_H_b", int'(h), 40);
        fwd(8'd129, 8'd128, l, h);
        chk("model_L_c", int'(l), 0);   chk("model_H_c", int'(h), 255);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single pair (228,167): 145 in the cycle after acceptance, then 56.
        base = log_data.size();
        send(8'd145, 8'd56, acc);
        drain();
        chk("single_even", log_data[base], 145);
        chk("single_odd", log_data[base + 1], 56);
        chk("single_latency", log_cyc[base], acc);
        chk("single_gap", log_cyc[base + 1] - log_cyc[base], 1);

        // Back-to-back pairs: four samples with no bubbles.
        base = log_data.size();
        send(8'd145, 8'd56, acc);
        send(8'd49, 8'd89, acc);
        drain();
        chk("b2b_s0", log_data[base], 145);
        chk("b2b_s1", log_data[base + 1], 56);
        chk("b2b_s2", log_data[base + 2], 49);
        chk("b2b_s3", log_data[base + 3], 89);
        for (int i = 1; i < 4; i++) chk("b2b_gap", log_cyc[base + i] - log_cyc[base + i - 1], 1);

        // Backpressure while in EVEN.
        base = log_data.size();
        out_ready = 1'b0;
        send(8'd145, 8'd56, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'(out_data), 145);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("bp_count", log_data.size() - base, 2);
        chk("bp_s0", log_data[base], 145);
        chk("bp_s1", log_data[base + 1], 56);

        // Modular wrap: L=0, H=255.
        base = log_data.size();
        send(8'd129, 8'd128, acc);
        drain();
        chk("wrap_even", log_data[base], 129);
        chk("wrap_odd", log_data[base + 1], 128);

        // Two full frames of random data with random backpressure.
        pulse_reset();
        base = log_data.size();
        toggle_en = 1'b1;
        for (int p = 0; p < 2 * PAIRS; p++) begin
            e = W'($urandom_range(0, 255));
            o = W'($urandom_range(0, 255));
            send(e, o, acc);
        end
        drain();
        toggle_en = 1'b0;
        out_ready = 1'b1;
        chk("frame_count", log_data.size() - base, 4 * PAIRS);
        lasts = 0;
        for (int i = base; i < log_last.size(); i++) lasts += log_last[i];
        chk("frame_last_total", lasts, 2);
        chk("frame_last_63", log_last[base + 63], 1);
        chk("frame_last_127", log_last[base + 127], 1);

        // Reset while in ODD, then a fresh frame.
        out_ready = 1'b0;
        send(8'd10, 8'd20, acc);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("odd_valid", int'(out_valid), 1);
        chk("odd_data", int'(out_data), 20);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = log_data.size();
        @(negedge clk);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_last", int'(out_last), 0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_emit", log_data.size() - base, 0);
        @(posedge clk);
        #1;
        for (int p = 0; p < PAIRS; p++) begin
            e = W'($urandom_range(0, 255));
            o = W'($urandom_range(0, 255));
            send(e, o, acc);
        end
        drain();
        chk("post_rst_count", log_data.size() - base, 2 * PAIRS);
        lasts = 0;
        for (int i = base; i < log_last.size(); i++) lasts += log_last[i];
        chk("post_rst_last_total", lasts, 1);
        chk("post_rst_last_63", log_last[base + 63], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
